// File: rtl/mux_4to1.sv
// mux_4to1: 4:1 data selector with combinational output y and a one-cycle
// registered copy y_q plus the select it was taken from (sel_q).
// Optional feature macro: MUX_4TO1_SELCNT_EN adds sel_chg_cnt, a saturating
// 8-bit count of edges on which the select differed from its registered value.
// Reset is synchronous and active-high.
module mux_4to1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             sel1,
    input  logic             sel2,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [1:0]       sel_q
`ifdef MUX_4TO1_SELCNT_EN
    ,
    output logic [7:0]       sel_chg_cnt
`endif
);

    logic [1:0]       sel;
    logic [WIDTH-1:0] y_d;
    logic [1:0]       sel_d;

    assign sel = {sel1, sel2};

    // Combinational selection; an unknown select falls to the default and
    // yields all-X so broken select wiring is visible in simulation.
    always_comb begin
        y = 'x;
        case (sel)
            2'b00:   y = a;
            2'b01:   y = b;
            2'b10:   y = c;
            2'b11:   y = d;
            default: y = 'x;
        endcase
    end

    // Next-state values for the output registers: cleared under reset,
    // otherwise a straight capture of the current selection.
    always_comb begin
        y_d   = y;
        sel_d = sel;
        if (rst) begin
            y_d   = '0;
            sel_d = 2'b00;
        end
    end

    // Output registers, one cycle behind y and the select.
    always_ff @(posedge clk) begin
        y_q   <= y_d;
        sel_q <= sel_d;
    end

`ifdef MUX_4TO1_SELCNT_EN
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Count select changes relative to the registered select, holding at
    // 8'hFF instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (rst) begin
            cnt_d = 8'h00;
        end else if ((sel != sel_q) && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'h01;
        end
    end

    // Select-change counter register.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign sel_chg_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux_4to1.sv
// tb_mux_4to1: table-driven check of mux_4to1 at WIDTH=8, followed by
// hand-written sequences for reset, same-edge changes and (when
// MUX_4TO1_SELCNT_EN is defined) the select-change counter.
module tb_mux_4to1;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] a, b, c, d;
    logic         sel1, sel2;
    logic [W-1:0] y, y_q;
    logic [1:0]   sel_q;
`ifdef MUX_4TO1_SELCNT_EN
    logic [7:0]   sel_chg_cnt;
`endif

    mux_4to1 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .sel1  (sel1),
        .sel2  (sel2),
        .y     (y),
        .y_q   (y_q),
        .sel_q (sel_q)
`ifdef MUX_4TO1_SELCNT_EN
        ,
        .sel_chg_cnt (sel_chg_cnt)
`endif
    );

    typedef struct {
        logic [W-1:0] a, b, c, d;
        logic [1:0]   s;
        logic [W-1:0] expY;
    } vector_t;

    vector_t vecs[16];
    int vectorCount = 0;
    int missCount   = 0;

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input vector_t v);
        a = v.a;
        b = v.b;
        c = v.c;
        d = v.d;
        {sel1, sel2} = v.s;
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    initial begin
        logic [W-1:0] prevY;
        logic [1:0]   prevS;
        vector_t      v;

        // a, b, c, d, select, expected y
        vecs[0]  = '{8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00};
        vecs[1]  = '{8'h01, 8'h00, 8'h00, 8'h00, 2'b00, 8'h01};
        vecs[2]  = '{8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 8'h00};
        vecs[3]  = '{8'h00, 8'h01, 8'h00, 8'h00, 2'b01, 8'h01};
        vecs[4]  = '{8'h00, 8'h00, 8'h00, 8'h00, 2'b10, 8'h00};
        vecs[5]  = '{8'h00, 8'h00, 8'h01, 8'h00, 2'b10, 8'h01};
        vecs[6]  = '{8'h00, 8'h00, 8'h00, 8'h00, 2'b11, 8'h00};
        vecs[7]  = '{8'h00, 8'h00, 8'h00, 8'h01, 2'b11, 8'h01};
        vecs[8]  = '{8'h01, 8'h00, 8'h01, 8'h01, 2'b01, 8'h00};
        vecs[9]  = '{8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 8'h00};
        vecs[10] = '{8'h01, 8'h00, 8'h01, 8'h01, 2'b01, 8'h00};
        vecs[11] = '{8'h11, 8'h22, 8'h44, 8'h88, 2'b00, 8'h11};
        vecs[12] = '{8'h11, 8'h22, 8'h44, 8'h88, 2'b01, 8'h22};
        vecs[13] = '{8'h11, 8'h22, 8'h44, 8'h88, 2'b10, 8'h44};
        vecs[14] = '{8'h11, 8'h22, 8'h44, 8'h88, 2'b11, 8'h88};
        vecs[15] = '{8'hFE, 8'h01, 8'hFD, 8'hFC, 2'b01, 8'h01};

        // Reset: registers clear while y keeps following its inputs.
        rst = 1'b1;
        a = 8'h01; b = 8'h00; c = 8'h00; d = 8'h00;
        {sel1, sel2} = 2'b00;
        @(posedge clk); #1;
        checkOutput("reset y_q", y_q, 8'h00);
        checkOutput("reset sel_q", {6'd0, sel_q}, 8'h00);
        checkOutput("y during reset", y, 8'h01);
        a = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;

        // Table sweep: y immediately, y_q/sel_q lag by exactly one edge.
        prevY = 8'h00;
        prevS = 2'b00;
        for (int i = 0; i < 16; i++) begin
            v = vecs[i];
            @(negedge clk);
            applyStimulus(v);
            #1;
            checkOutput($sformatf("vec%0d y", i), y, v.expY);
            checkOutput($sformatf("vec%0d y_q before edge", i), y_q, prevY);
            @(posedge clk); #1;
            checkOutput($sformatf("vec%0d y_q", i), y_q, v.expY);
            checkOutput($sformatf("vec%0d sel_q", i), {6'd0, sel_q}, {6'd0, v.s});
            prevY = v.expY;
            prevS = v.s;
        end

        // Reset mid-stream with y_q=1, sel_q=11, then release.
        @(negedge clk);
        a = 8'h00; b = 8'h00; c = 8'h00; d = 8'h01;
        {sel1, sel2} = 2'b11;
        @(posedge clk); #1;
        checkOutput("pre-reset y_q", y_q, 8'h01);
        checkOutput("pre-reset sel_q", {6'd0, sel_q}, 8'h03);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("mid reset y_q", y_q, 8'h00);
        checkOutput("mid reset sel_q", {6'd0, sel_q}, 8'h00);
        checkOutput("mid reset y", y, 8'h01);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("post reset y_q", y_q, 8'h01);
        checkOutput("post reset sel_q", {6'd0, sel_q}, 8'h03);

        // Select and data change together just before the edge.
        @(negedge clk);
        #4;
        a = 8'h5A; b = 8'h00; c = 8'hC3; d = 8'h00;
        {sel1, sel2} = 2'b10;
        @(posedge clk); #1;
        checkOutput("late change y_q", y_q, 8'hC3);
        checkOutput("late change sel_q", {6'd0, sel_q}, 8'h02);

        // Unselected inputs toggling on the capture edge are ignored.
        @(negedge clk);
        #4;
        a = 8'hA5; b = 8'hFF; d = 8'h77;
        @(posedge clk); #1;
        checkOutput("toggle unselected y", y, 8'hC3);
        checkOutput("toggle unselected y_q", y_q, 8'hC3);

`ifdef MUX_4TO1_SELCNT_EN
        // Counter: cleared by reset, counts 00->01->10->11 as three changes,
        // then saturates at 255 under continuous toggling.
        @(negedge clk);
        rst = 1'b1;
        {sel1, sel2} = 2'b00;
        @(posedge clk); #1;
        checkOutput("cnt after reset", sel_chg_cnt, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            {sel1, sel2} = 2'(s);
            @(posedge clk);
        end
        #1;
        checkOutput("cnt after sweep", sel_chg_cnt, 8'h03);
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            {sel1, sel2} = (i % 2 == 1) ? 2'b00 : 2'b11;
            @(posedge clk); #1;
            if (i == 251) checkOutput("cnt at 254", sel_chg_cnt, 8'hFE);
        end
        checkOutput("cnt saturated", sel_chg_cnt, 8'hFF);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("cnt cleared", sel_chg_cnt, 8'h00);
        rst = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
